// File: rtl/rv32i_core_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memory system.
// The master side is the sequencer; the slave side is the memory/IR logic.
interface rv32i_core_sequencer_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic        ir_we;
    logic        dm_req;
    logic        dm_we;
    logic        dm_ack;

    modport master (
        output im_req, im_addr, ir_we, dm_req, dm_we,
        input  im_ack, dm_ack
    );

    modport slave (
        input  im_req, im_addr, ir_we, dm_req, dm_we,
        output im_ack, dm_ack
    );
endinterface

// File: rtl/rv32i_core_sequencer.sv
// Multi-cycle RV32I control sequencer: owns the PC and steps each instruction through
// fetch/decode/execute/memory/writeback, with synchronous traps and bus-timeout faults.
module rv32i_core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010,
    parameter logic [7:0]  TIMEOUT     = 8'd15
) (
    input  logic                           clk,
    input  logic                           resetb,
    rv32i_core_sequencer_if.master         mem_bus,
    input  logic                           dec_regwrite,
    input  logic                           dec_jump,
    input  logic                           dec_jr,
    input  logic                           dec_br,
    input  logic                           dec_load,
    input  logic                           dec_store,
    input  logic                           dec_ill,
    input  logic                           dec_mis,
    input  logic                           br_taken,
    input  logic [31:0]                    target,
    output logic                           rf_we,
    output logic [31:0]                    pc,
    output logic                           trap,
    output logic [31:0]                    mepc,
    output logic [3:0]                     mcause,
    output logic [31:0]                    instret
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mepc_q, mepc_d;
    logic [3:0]  mcause_q, mcause_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] instret_q, instret_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        redirect;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            mepc_q    <= '0;
            mcause_q  <= '0;
            cause_q   <= '0;
            instret_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            cnt_q     <= cnt_d;
        end
    end

    // Requests depend only on state, so an async reset drops them immediately.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        cnt_d     = '0;
        redirect  = dec_jump | dec_jr | (dec_br & br_taken);

        mem_bus.im_req = 1'b0;
        mem_bus.ir_we  = 1'b0;
        mem_bus.dm_req = 1'b0;
        mem_bus.dm_we  = 1'b0;
        rf_we          = 1'b0;
        trap           = 1'b0;

        unique case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                mem_bus.im_req = 1'b1;
                if (mem_bus.im_ack) begin
                    mem_bus.ir_we = 1'b1;
                    state_d       = DECODE;
                end else if (cnt_q == TIMEOUT) begin
                    cause_d = 4'd1;
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DECODE: begin
                if (dec_ill) begin
                    cause_d = 4'd2;
                    state_d = TRAP;
                end else if (dec_mis && dec_load) begin
                    cause_d = 4'd4;
                    state_d = TRAP;
                end else if (dec_mis && dec_store) begin
                    cause_d = 4'd6;
                    state_d = TRAP;
                end else if (dec_load || dec_store) begin
                    state_d = MEM;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (redirect && (target[1:0] != 2'b00)) begin
                    cause_d = 4'd0;
                    state_d = TRAP;
                end else begin
                    rf_we     = dec_regwrite;
                    pc_d      = redirect ? target : pc_q + 32'd4;
                    instret_d = instret_q + 32'd1;
                    state_d   = FETCH;
                end
            end

            MEM: begin
                mem_bus.dm_req = 1'b1;
                mem_bus.dm_we  = dec_store;
                if (mem_bus.dm_ack) begin
                    if (dec_store) begin
                        pc_d      = pc_q + 32'd4;
                        instret_d = instret_q + 32'd1;
                        state_d   = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (cnt_q == TIMEOUT) begin
                    cause_d = dec_store ? 4'd7 : 4'd5;
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WB: begin
                rf_we     = 1'b1;
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                state_d   = FETCH;
            end

            TRAP: begin
                trap     = 1'b1;
                mepc_d   = pc_q;
                mcause_d = cause_q;
                pc_d     = TRAP_VECTOR;
                state_d  = FETCH;
            end

            default: state_d = IDLE;
        endcase
    end

    assign mem_bus.im_addr = pc_q;
    assign pc              = pc_q;
    assign mepc            = mepc_q;
    assign mcause          = mcause_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_rv32i_core_sequencer.sv
// Directed table-driven bench for rv32i_core_sequencer: one record per instruction,
// plus a hand-written async-reset-during-memory-wait sequence.
module tb_rv32i_core_sequencer;

    localparam logic [8:0] F_RW  = 9'b1_0000_0000;
    localparam logic [8:0] F_JMP = 9'b0_1000_0000;
    localparam logic [8:0] F_JR  = 9'b0_0100_0000;
    localparam logic [8:0] F_BR  = 9'b0_0010_0000;
    localparam logic [8:0] F_LD  = 9'b0_0001_0000;
    localparam logic [8:0] F_ST  = 9'b0_0000_1000;
    localparam logic [8:0] F_ILL = 9'b0_0000_0100;
    localparam logic [8:0] F_MIS = 9'b0_0000_0010;
    localparam logic [8:0] F_BT  = 9'b0_0000_0001;

    typedef struct {
        logic [8:0]  flags;
        logic [31:0] target;
        int          im_delay;
        int          dm_delay;
        logic [31:0] addr;
        int          ireq;
        int          irwe;
        int          dreq;
        logic        dwe;
        int          rf;
        int          trp;
        logic [31:0] pc;
        logic [31:0] instret;
        logic [3:0]  mcause;
        logic [31:0] mepc;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        dec_regwrite = 1'b0, dec_jump = 1'b0, dec_jr = 1'b0, dec_br = 1'b0;
    logic        dec_load = 1'b0, dec_store = 1'b0, dec_ill = 1'b0, dec_mis = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] target = '0;
    logic        rf_we, trap;
    logic [31:0] pc, mepc, instret;
    logic [3:0]  mcause;

    int checks = 0;
    int errors = 0;

    int          o_ireq, o_irwe, o_dreq, o_rf, o_trap;
    logic        o_dwe;
    logic [31:0] o_addr;

    vec_t vecs[18];

    rv32i_core_sequencer_if bus ();

    rv32i_core_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0010),
        .TIMEOUT     (8'd15)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .mem_bus      (bus),
        .dec_regwrite (dec_regwrite),
        .dec_jump     (dec_jump),
        .dec_jr       (dec_jr),
        .dec_br       (dec_br),
        .dec_load     (dec_load),
        .dec_store    (dec_store),
        .dec_ill      (dec_ill),
        .dec_mis      (dec_mis),
        .br_taken     (br_taken),
        .target       (target),
        .rf_we        (rf_we),
        .pc           (pc),
        .trap         (trap),
        .mepc         (mepc),
        .mcause       (mcause),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [8:0] flags, input logic [31:0] tgt,
                                input int imd, input int dmd, input logic [31:0] addr,
                                input int ireq, input int irwe, input int dreq, input logic dwe,
                                input int rf, input int trp, input logic [31:0] epc,
                                input logic [31:0] eret, input logic [3:0] ecause,
                                input logic [31:0] emepc);
        vec_t v;
        v.flags = flags;  v.target = tgt;  v.im_delay = imd;  v.dm_delay = dmd;
        v.addr = addr;    v.ireq = ireq;   v.irwe = irwe;     v.dreq = dreq;
        v.dwe = dwe;      v.rf = rf;       v.trp = trp;       v.pc = epc;
        v.instret = eret; v.mcause = ecause; v.mepc = emepc;
        return v;
    endfunction

    // Entered at a negedge; returns at the negedge where the next fetch begins.
    task automatic run_instr(input vec_t v);
        bit started = 0, left = 0, done = 0;
        o_ireq = 0; o_irwe = 0; o_dreq = 0; o_rf = 0; o_trap = 0;
        o_dwe = 1'b0; o_addr = 'x;
        {dec_regwrite, dec_jump, dec_jr, dec_br, dec_load,
         dec_store, dec_ill, dec_mis, br_taken} = v.flags;
        target = v.target;
        for (int g = 0; g < 200 && !done; g++) begin
            if (bus.im_req && left) begin
                done = 1;
            end else begin
                if (bus.im_req) begin
                    if (!started) o_addr = bus.im_addr;
                    started = 1;
                    o_ireq++;
                end else if (started) begin
                    left = 1;
                end
                if (bus.dm_req) begin
                    o_dreq++;
                    o_dwe = o_dwe | bus.dm_we;
                end
                o_rf   += int'(rf_we);
                o_trap += int'(trap);
                bus.im_ack = bus.im_req && (o_ireq - 1 == v.im_delay);
                bus.dm_ack = bus.dm_req && (o_dreq - 1 == v.dm_delay);
                #1;
                o_irwe += int'(bus.ir_we);
                @(negedge clk);
            end
        end
        bus.im_ack = 1'b0;
        bus.dm_ack = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL instr_timeout: got no next fetch within 200 cycles expected one");
        end
    endtask

    initial begin
        bus.im_ack = 1'b0;
        bus.dm_ack = 1'b0;

        //               flags          target        imd  dmd  addr          ireq irwe dreq dwe rf trp pc            instret mcause mepc
        vecs[0]  = mk(F_RW,          32'h0,        2,   0,   32'h0,        3,   1,   0,   0,  1, 0,  32'h4,        1,  0, 32'h0);
        vecs[1]  = mk(F_RW,          32'h0,        0,   0,   32'h4,        1,   1,   0,   0,  1, 0,  32'h8,        2,  0, 32'h0);
        vecs[2]  = mk(F_RW|F_LD,     32'h0,        0,   3,   32'h8,        1,   1,   4,   0,  1, 0,  32'hC,        3,  0, 32'h0);
        vecs[3]  = mk(F_ST,          32'h0,        1,   1,   32'hC,        2,   1,   2,   1,  0, 0,  32'h10,       4,  0, 32'h0);
        vecs[4]  = mk(F_RW|F_JMP,    32'h100,      0,   0,   32'h10,       1,   1,   0,   0,  1, 0,  32'h100,      5,  0, 32'h0);
        vecs[5]  = mk(F_BR|F_BT,     32'h102,      0,   0,   32'h100,      1,   1,   0,   0,  0, 1,  32'h10,       5,  0, 32'h100);
        vecs[6]  = mk(F_BR,          32'h102,      0,   0,   32'h10,       1,   1,   0,   0,  0, 0,  32'h14,       6,  0, 32'h100);
        vecs[7]  = mk(F_RW|F_JMP,    32'h20,       0,   0,   32'h14,       1,   1,   0,   0,  1, 0,  32'h20,       7,  0, 32'h100);
        vecs[8]  = mk(F_RW|F_ILL,    32'h0,        0,   0,   32'h20,       1,   1,   0,   0,  0, 1,  32'h10,       7,  2, 32'h20);
        vecs[9]  = mk(F_MIS|F_LD,    32'h0,        0,   0,   32'h10,       1,   1,   0,   0,  0, 1,  32'h10,       7,  4, 32'h10);
        vecs[10] = mk(F_MIS|F_ST,    32'h0,        0,   0,   32'h10,       1,   1,   0,   0,  0, 1,  32'h10,       7,  6, 32'h10);
        vecs[11] = mk(F_RW,          32'h0,        255, 0,   32'h10,       16,  0,   0,   0,  0, 1,  32'h10,       7,  1, 32'h10);
        vecs[12] = mk(F_RW,          32'h0,        15,  0,   32'h10,       16,  1,   0,   0,  1, 0,  32'h14,       8,  1, 32'h10);
        vecs[13] = mk(F_RW|F_LD,     32'h0,        0,   255, 32'h14,       1,   1,   16,  0,  0, 1,  32'h10,       8,  5, 32'h14);
        vecs[14] = mk(F_ST,          32'h0,        0,   255, 32'h10,       1,   1,   16,  1,  0, 1,  32'h10,       8,  7, 32'h10);
        vecs[15] = mk(F_ST,          32'h0,        0,   15,  32'h10,       1,   1,   16,  1,  0, 0,  32'h14,       9,  7, 32'h10);
        vecs[16] = mk(F_RW|F_JR,     32'hFFFF_FFFC,0,   0,   32'h14,       1,   1,   0,   0,  1, 0,  32'hFFFF_FFFC,10, 7, 32'h10);
        vecs[17] = mk(F_RW,          32'h0,        0,   0,   32'hFFFF_FFFC,1,   1,   0,   0,  1, 0,  32'h0,        11, 7, 32'h10);

        repeat (3) @(negedge clk);
        chk("rst_pc",      pc,                 32'h0);
        chk("rst_instret", instret,            32'h0);
        chk("rst_mepc",    mepc,               32'h0);
        chk("rst_mcause",  {28'h0, mcause},    32'h0);
        chk("rst_reqs",    {30'h0, bus.im_req, bus.dm_req}, 32'h0);

        resetb = 1'b1;
        #1;
        chk("idle_no_req", {31'h0, bus.im_req}, 32'h0);
        @(negedge clk);
        chk("fetch_after_idle", {31'h0, bus.im_req}, 32'h1);

        for (int i = 0; i < 18; i++) begin
            run_instr(vecs[i]);
            chk($sformatf("v%0d_addr", i),    o_addr,              vecs[i].addr);
            chk($sformatf("v%0d_imreq", i),   32'(o_ireq),         32'(vecs[i].ireq));
            chk($sformatf("v%0d_irwe", i),    32'(o_irwe),         32'(vecs[i].irwe));
            chk($sformatf("v%0d_dmreq", i),   32'(o_dreq),         32'(vecs[i].dreq));
            chk($sformatf("v%0d_dmwe", i),    {31'h0, o_dwe},      {31'h0, vecs[i].dwe});
            chk($sformatf("v%0d_rfwe", i),    32'(o_rf),           32'(vecs[i].rf));
            chk($sformatf("v%0d_trap", i),    32'(o_trap),         32'(vecs[i].trp));
            chk($sformatf("v%0d_pc", i),      pc,                  vecs[i].pc);
            chk($sformatf("v%0d_instret", i), instret,             vecs[i].instret);
            chk($sformatf("v%0d_mcause", i),  {28'h0, mcause},     {28'h0, vecs[i].mcause});
            chk($sformatf("v%0d_mepc", i),    mepc,                vecs[i].mepc);
        end

        // Reset asserted while a load is waiting for dm_ack.
        {dec_regwrite, dec_jump, dec_jr, dec_br, dec_load,
         dec_store, dec_ill, dec_mis, br_taken} = F_RW | F_LD;
        begin
            bit seen = 0;
            for (int g = 0; g < 50 && !seen; g++) begin
                bus.im_ack = bus.im_req;
                @(negedge clk);
                seen = bus.dm_req;
            end
            bus.im_ack = 1'b0;
            chk("mem_wait_reached", {31'h0, seen}, 32'h1);
        end
        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        chk("async_dm_req_drop", {31'h0, bus.dm_req}, 32'h0);
        chk("async_pc",          pc,                  32'h0);
        chk("async_instret",     instret,             32'h0);
        @(negedge clk);
        resetb = 1'b1;
        #1;
        chk("rerelease_idle", {30'h0, bus.im_req, bus.dm_req}, 32'h0);
        @(negedge clk);
        chk("rerelease_fetch", {31'h0, bus.im_req}, 32'h1);
        chk("rerelease_addr",  bus.im_addr,          32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
